// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared FSM state type and MAC pipeline timing constants
// for the MAC operand sequencer.
package mac_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      RESULT = 2'd3
   } state_t;

   // The MAC registers the product on one edge and accumulates on the next.
   localparam int MAC_LATENCY  = 2;
   // One extra cycle so the accumulator has settled before it is sampled.
   localparam int DRAIN_CYCLES = MAC_LATENCY + 1;

endpackage

// File: rtl/mac_seq_fifo.sv
// mac_seq_fifo: small synchronous FIFO holding operand pairs (plus optional
// last flag) between the input stream and the MAC issue logic.
// DEPTH must be a power of two so the pointers wrap naturally.
module mac_seq_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             a_reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   // Next-state for storage, pointers and occupancy; push and pop may coincide.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Register the FIFO state; reset discards every buffered pair.
   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: feeds buffered operand pairs to the 8-bit MAC one per
// cycle and reports each vector's dot product as the accumulator difference
// across the vector (the MAC is never cleared).
// Optional feature macro MAC_SEQ_LAST_EN: adds in_last so a vector may end
// early on a flagged element.
module mac_operand_sequencer
   import mac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_LEN    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    a_reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_a,
   input  logic [DATA_WIDTH-1:0]   in_b,
`ifdef MAC_SEQ_LAST_EN
   input  logic                    in_last,
`endif
   output logic [DATA_WIDTH-1:0]   op_a,
   output logic [DATA_WIDTH-1:0]   op_b,
   input  logic [2*DATA_WIDTH-1:0] mac_result,
   output logic                    dot_valid,
   input  logic                    dot_ready,
   output logic [2*DATA_WIDTH-1:0] dot_out,
   output logic                    busy
);

   localparam int DW = DATA_WIDTH;
   localparam int PW = 2 * DATA_WIDTH;
`ifdef MAC_SEQ_LAST_EN
   localparam int ENTRY_W = PW + 1;
`else
   localparam int ENTRY_W = PW;
`endif
   localparam int CNT_W  = $clog2(VEC_LEN + 1);
   localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0]  VEC_LEN_C = CNT_W'(VEC_LEN);
   localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DRAIN_CYCLES - 1);

   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_wdata, fifo_head;
   logic [DW-1:0]      head_a, head_b;
   logic               head_last;
   logic [CNT_W-1:0]   cnt_next;
   logic               last_elem;

   state_t             state_q, state_d;
   logic [DW-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
   logic [PW-1:0]      base_q, base_d;
   logic [PW-1:0]      dot_out_q, dot_out_d;
   logic               dot_valid_q, dot_valid_d;

`ifdef MAC_SEQ_LAST_EN
   assign fifo_wdata = {in_last, in_a, in_b};
   assign head_last  = fifo_head[PW];
`else
   assign fifo_wdata = {in_a, in_b};
   assign head_last  = 1'b0;
`endif

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && !fifo_full;
   assign head_a    = fifo_head[PW-1:DW];
   assign head_b    = fifo_head[DW-1:0];

   mac_seq_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .a_reset (a_reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wdata   (fifo_wdata),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Element index the head pair would take if popped now, and whether it closes the vector.
   always_comb begin
      cnt_next  = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      last_elem = (cnt_next == VEC_LEN_C) || head_last;
   end

   // Next-state and issue logic; operands default to the 0/0 bubble every cycle.
   always_comb begin
      state_d     = state_q;
      op_a_d      = '0;
      op_b_d      = '0;
      cnt_d       = cnt_q;
      dcnt_d      = dcnt_q;
      base_d      = base_q;
      dot_out_d   = dot_out_q;
      dot_valid_d = dot_valid_q;
      fifo_pop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               op_a_d   = head_a;
               op_b_d   = head_b;
               base_d   = mac_result;
               cnt_d    = cnt_next;
               if (last_elem) begin
                  dcnt_d  = '0;
                  state_d = DRAIN;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               op_a_d   = head_a;
               op_b_d   = head_b;
               cnt_d    = cnt_next;
               if (last_elem) begin
                  dcnt_d  = '0;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_q + DCNT_W'(1);
            if (dcnt_q == LAST_DCNT) begin
               dot_out_d   = mac_result - base_q;
               dot_valid_d = 1'b1;
               state_d     = RESULT;
            end
         end
         RESULT: begin
            if (dot_ready) begin
               dot_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state register; reset returns to IDLE with all outputs cleared.
   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         cnt_q       <= '0;
         dcnt_q      <= '0;
         base_q      <= '0;
         dot_out_q   <= '0;
         dot_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         cnt_q       <= cnt_d;
         dcnt_q      <= dcnt_d;
         base_q      <= base_d;
         dot_out_q   <= dot_out_d;
         dot_valid_q <= dot_valid_d;
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign dot_out   = dot_out_q;
   assign dot_valid = dot_valid_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: bench for the MAC operand sequencer together with
// a behavioural 2-stage MAC; dot products are predicted from the accepted pairs.
module tb_mac_operand_sequencer;

   localparam int DW = 8;
   localparam int VL = 4;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          a_reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0;
   logic [DW-1:0] in_b = '0;
   logic [DW-1:0] op_a, op_b;
   logic [15:0]   mac_result;
   logic          dot_valid;
   logic          dot_ready = 1'b0;
   logic [15:0]   dot_out;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   mac_operand_sequencer #(
      .DATA_WIDTH (DW),
      .VEC_LEN    (VL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk        (clk),
      .a_reset    (a_reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
`ifdef MAC_SEQ_LAST_EN
      .in_last    (1'b0),
`endif
      .op_a       (op_a),
      .op_b       (op_b),
      .mac_result (mac_result),
      .dot_valid  (dot_valid),
      .dot_ready  (dot_ready),
      .dot_out    (dot_out),
      .busy       (busy)
   );

   // Behavioural MAC: product registered on one edge, accumulated on the next.
   logic [15:0] mac_prod_q, mac_acc_q;
   always @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         mac_prod_q <= '0;
         mac_acc_q  <= '0;
      end else begin
         mac_prod_q <= 16'(op_a) * 16'(op_b);
         mac_acc_q  <= mac_acc_q + mac_prod_q;
      end
   end
   assign mac_result = mac_acc_q;

   // Observation log gathered away from the active edge.
   int          cyc = 0;
   int          last_op_cyc = 0;
   int          rise_cyc = 0;
   int          rise_count = 0;
   int          hold_err = 0;
   bit          dv_prev = 1'b0;
   logic [15:0] dot_prev = '0;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_reset) begin
         dv_prev = 1'b0;
      end else begin
         if (op_a != 0 || op_b != 0) last_op_cyc = cyc;
         if (dot_valid && !dv_prev) begin
            rise_cyc = cyc;
            rise_count++;
         end
         if (dot_valid && dv_prev && dot_out !== dot_prev) hold_err++;
         if (dot_valid && dot_ready) got_q.push_back(dot_out);
         dv_prev  = dot_valid;
         dot_prev = dot_out;
      end
   end

   // Reference model: every VL accepted pairs form a vector; dot = sum of a*b mod 2^16.
   int cur_sum = 0;
   int cur_n   = 0;
   bit rand_ready = 1'b0;

   task automatic model_accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
      cur_sum += int'(a) * int'(b);
      cur_n++;
      if (cur_n == VL) begin
         exp_q.push_back(16'(cur_sum));
         cur_sum = 0;
         cur_n   = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) dot_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push_one(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
      bit acc;
      ok       = 1'b0;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         acc = in_ready;
         tick();
         if (acc) begin
            ok = 1'b1;
            model_accept(a, b);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   logic [DW-1:0] va[VL];
   logic [DW-1:0] vb[VL];

   task automatic push_vec(output bit ok);
      bit one;
      ok = 1'b1;
      for (int i = 0; i < VL; i++) begin
         push_one(va[i], vb[i], one);
         ok &= one;
      end
   endtask

   task automatic wait_dots(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (got_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic set_vec1();
      for (int i = 0; i < VL; i++) begin
         va[i] = 8'(i + 1);
         vb[i] = 8'(i + 5);
      end
   endtask

   task automatic test_reset();
      a_reset  = 1'b1;
      in_valid = 1'b0;
      dot_ready = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (op_a !== 8'd0 || op_b !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_op: got %0d/%0d expected 0/0", op_a, op_b);
      end
      n_checks++;
      if (dot_valid !== 1'b0 || dot_out !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_dot: got valid=%0d out=%0d expected 0/0", dot_valid, dot_out);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_busy: got %0d expected 0", busy);
      end
      a_reset = 1'b0;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_in_ready: got %0d expected 1", in_ready);
      end
   endtask

   task automatic test_basic();
      bit ok, okw;
      int r0;
      logic [15:0] g, e;
      dot_ready = 1'b1;
      set_vec1();
      r0 = rise_count;
      push_vec(ok);
      wait_dots(1, okw);
      repeat (6) tick();
      n_checks++;
      if (!(ok && okw)) begin
         n_fail++;
         $display("[TB] FAIL basic_timeout: got push=%0d dot=%0d expected 1/1", ok, okw);
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("[TB] FAIL basic_dot: got %0d expected %0d", g, e);
         end
         n_checks++;
         if (rise_cyc - last_op_cyc != 3) begin
            n_fail++;
            $display("[TB] FAIL basic_latency: got %0d edges expected 3", rise_cyc - last_op_cyc);
         end
         n_checks++;
         if (rise_count - r0 != 1) begin
            n_fail++;
            $display("[TB] FAIL basic_pulses: got %0d expected 1", rise_count - r0);
         end
      end
   endtask

   task automatic test_no_clear();
      bit ok, okw;
      logic [15:0] g, e;
      for (int i = 0; i < VL; i++) begin
         va[i] = 8'd1;
         vb[i] = 8'd1;
      end
      push_vec(ok);
      wait_dots(1, okw);
      n_checks++;
      if (!(ok && okw)) begin
         n_fail++;
         $display("[TB] FAIL noclear_timeout: got push=%0d dot=%0d expected 1/1", ok, okw);
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("[TB] FAIL noclear_dot: got %0d expected %0d", g, e);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_wrap();
      bit ok, okw;
      int d, q;
      logic [15:0] g, e;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            d = int'(16'(16'hFFF0 - mac_acc_q));
            q = d / 255;
            va[0] = 8'd255; vb[0] = (q > 255) ? 8'd255 : 8'(q);
            va[1] = 8'd255; vb[1] = (q > 255) ? 8'(q - 255) : 8'd0;
            va[2] = 8'(d % 255); vb[2] = 8'd1;
            va[3] = 8'd0; vb[3] = 8'd0;
            push_vec(ok);
            wait_dots(1, okw);
            repeat (3) tick();
            n_checks++;
            if (!(ok && okw) || mac_acc_q !== 16'hFFF0) begin
               n_fail++;
               $display("[TB] FAIL wrap_preacc: got acc=%0h ok=%0d expected acc=fff0 ok=1", mac_acc_q, ok && okw);
            end
            if (got_q.size() > 0) void'(got_q.pop_front());
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         for (int i = 0; i < VL; i++) begin
            va[i] = 8'd255;
            vb[i] = 8'd255;
         end
         push_vec(ok);
         wait_dots(1, okw);
         n_checks++;
         if (!(ok && okw)) begin
            n_fail++;
            $display("[TB] FAIL wrap_timeout: got push=%0d dot=%0d expected 1/1", ok, okw);
         end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
               n_fail++;
               $display("[TB] FAIL wrap_dot_pass%0d: got %0d expected %0d", pass, g, e);
            end
         end
         repeat (3) tick();
      end
   endtask

   task automatic test_stall_gap();
      bit ok0, ok1, ok2, ok3, okw;
      logic [15:0] g, e;
      set_vec1();
      push_one(va[0], vb[0], ok0);
      push_one(va[1], vb[1], ok1);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i >= 1) begin
            n_checks++;
            if (op_a !== 8'd0 || op_b !== 8'd0) begin
               n_fail++;
               $display("[TB] FAIL gap_bubble_%0d: got %0d/%0d expected 0/0", i, op_a, op_b);
            end
         end
      end
      push_one(va[2], vb[2], ok2);
      push_one(va[3], vb[3], ok3);
      wait_dots(1, okw);
      n_checks++;
      if (!(ok0 && ok1 && ok2 && ok3 && okw)) begin
         n_fail++;
         $display("[TB] FAIL gap_timeout: got 0 expected 1");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("[TB] FAIL gap_dot: got %0d expected %0d", g, e);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_backpressure();
      bit ok, okw, acc, seen;
      int idx, h0, drops;
      logic [DW-1:0] pa[6];
      logic [DW-1:0] pb[6];
      logic [15:0] g, e;
      dot_ready = 1'b0;
      set_vec1();
      push_vec(ok);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (dot_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!(ok && seen)) begin
         n_fail++;
         $display("[TB] FAIL bp_timeout: got push=%0d valid=%0d expected 1/1", ok, seen);
      end
      for (int i = 0; i < 6; i++) begin
         pa[i] = 8'($urandom_range(0, 255));
         pb[i] = 8'($urandom_range(0, 255));
      end
      idx   = 0;
      drops = 0;
      h0    = hold_err;
      for (int c = 0; c < 10; c++) begin
         acc = 1'b0;
         if (idx < 6) begin
            in_valid = 1'b1;
            in_a     = pa[idx];
            in_b     = pb[idx];
            acc      = in_ready;
         end
         tick();
         if (acc) begin
            model_accept(pa[idx], pb[idx]);
            idx++;
         end
         if (!dot_valid) drops++;
      end
      n_checks++;
      if (idx != FD || in_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL bp_full: got accepted=%0d in_ready=%0d expected %0d/0", idx, in_ready, FD);
      end
      n_checks++;
      if (drops != 0 || hold_err != h0) begin
         n_fail++;
         $display("[TB] FAIL bp_hold: got drops=%0d changes=%0d expected 0/0", drops, hold_err - h0);
      end
      n_checks++;
      if (exp_q.size() == 0 || dot_out !== exp_q[0]) begin
         n_fail++;
         $display("[TB] FAIL bp_dot_held: got %0d expected %0d", dot_out, (exp_q.size() > 0) ? exp_q[0] : 16'd0);
      end
      in_valid  = 1'b0;
      dot_ready = 1'b1;
      for (int i = idx; i < 6; i++) push_one(pa[i], pb[i], ok);
      for (int i = 0; i < 2; i++) push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ok);
      wait_dots(3, okw);
      n_checks++;
      if (!okw) begin
         n_fail++;
         $display("[TB] FAIL bp_drain_timeout: got %0d dots expected 3", got_q.size());
      end
      for (int k = 0; k < 3; k++) begin
         if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
               n_fail++;
               $display("[TB] FAIL bp_dot_%0d: got %0d expected %0d", k, g, e);
            end
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      bit ok0, ok1, ok, okw, busy_seen;
      logic [15:0] g, e;
      dot_ready = 1'b1;
      push_one(8'd1, 8'd5, ok0);
      push_one(8'd2, 8'd6, ok1);
      tick();
      n_checks++;
      if (busy !== 1'b1 || op_a !== 8'd2 || op_b !== 8'd6) begin
         n_fail++;
         $display("[TB] FAIL mid_issue: got busy=%0d op=%0d/%0d expected 1 2/6", busy, op_a, op_b);
      end
      a_reset = 1'b1;
      #1;
      n_checks++;
      if (op_a !== 8'd0 || op_b !== 8'd0 || busy !== 1'b0 || dot_valid !== 1'b0 || dot_out !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_outputs: got op=%0d/%0d busy=%0d dv=%0d dot=%0d expected all 0",
                  op_a, op_b, busy, dot_valid, dot_out);
      end
      cur_sum = 0;
      cur_n   = 0;
      exp_q.delete();
      got_q.delete();
      repeat (2) tick();
      a_reset = 1'b0;
      busy_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy || op_a != 0 || op_b != 0) busy_seen = 1'b1;
      end
      n_checks++;
      if (busy_seen || in_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_fifo_empty: got activity=%0d in_ready=%0d expected 0/1", busy_seen, in_ready);
      end
      set_vec1();
      push_vec(ok);
      wait_dots(1, okw);
      n_checks++;
      if (!(ok && okw)) begin
         n_fail++;
         $display("[TB] FAIL mid_timeout: got 0 expected 1");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("[TB] FAIL mid_fresh_dot: got %0d expected %0d", g, e);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_random_stream();
      bit ok, okw;
      logic [15:0] g, e;
      rand_ready = 1'b1;
      for (int p = 0; p < 6 * VL; p++) begin
         push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ok);
         repeat ($urandom_range(0, 2)) tick();
      end
      wait_dots(6, okw);
      n_checks++;
      if (!okw) begin
         n_fail++;
         $display("[TB] FAIL rand_timeout: got %0d dots expected 6", got_q.size());
      end
      for (int k = 0; k < 6; k++) begin
         if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
               n_fail++;
               $display("[TB] FAIL rand_dot_%0d: got %0d expected %0d", k, g, e);
            end
         end
      end
      rand_ready = 1'b0;
      dot_ready  = 1'b1;
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_basic();
      test_no_clear();
      test_wrap();
      test_stall_gap();
      test_backpressure();
      test_reset_mid();
      test_random_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
